// File: rtl/s35932_misr_pkg.sv
// s35932_misr_pkg: shared state encoding, MISR update and LEN clamp helpers
package s35932_misr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Widest signature the helpers can handle; callers pass their real width in w
    localparam int MW = 64;

    function automatic logic [MW-1:0] misr_next(
        input logic [MW-1:0] sig,
        input logic [MW-1:0] din,
        input logic [MW-1:0] poly,
        input int            w,
        input logic          tm0,
        input logic          tm1
    );
        logic [MW-1:0] mask;
        logic          msb;
        mask = (w >= MW) ? '1 : ((MW'(1) << w) - MW'(1));
        msb  = |(sig & (MW'(1) << (w - 1)));
        return tm0 ? ((din ^ MW'(tm1)) & mask)
                   : (((sig << 1) ^ (msb ? poly : '0) ^ din ^ MW'(tm1)) & mask);
    endfunction

    // Zero-length requests still compress one word; oversize requests saturate
    function automatic int clamp_len(input int len, input int maxlen);
        return (len == 0) ? 1 : (len > maxlen) ? maxlen : len;
    endfunction

endpackage

// File: rtl/s35932_misr_compactor_step.sv
// s35932_misr_step: combinational next-signature calculator
module s35932_misr_step
    import s35932_misr_pkg::*;
#(
    parameter int          WIDTH = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] din,
    input  logic             tm0,
    input  logic             tm1,
    output logic [WIDTH-1:0] next
);

    assign next = WIDTH'(misr_next(MW'(sig), MW'(din), MW'(POLY), WIDTH, tm0, tm1));

endmodule

// File: rtl/s35932_misr_compactor.sv
// s35932_misr_compactor: folds a word stream into a MISR signature with valid/ack hand-off
module s35932_misr_compactor
    import s35932_misr_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [31:0]      POLY   = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED   = '0,
    parameter int               MAXLEN = 256,
    localparam int              LW     = $clog2(MAXLEN + 1)
) (
    input  logic             CK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [LW-1:0]    LEN,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    input  logic             TM0,
    input  logic             TM1,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] SIG,
    output logic             SIG_VALID,
    input  logic             SIG_ACK,
    output logic             BUSY
);

    state_t           state, state_next;
    logic [WIDTH-1:0] sig_next;
    logic [LW-1:0]    count, len_q;
    logic             accept, last;

    s35932_misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
        .sig  (SIG),
        .din  (DIN),
        .tm0  (TM0),
        .tm1  (TM1),
        .next (sig_next)
    );

    assign accept = (state == RUN) && DIN_VALID;
    assign last   = accept && ((count + LW'(1)) == len_q);

    // State register; reset abandons any signature in progress
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    // Next state and handshake outputs; CLEAR outranks every other event
    always_comb begin
        state_next = state;
        DIN_READY  = 1'b0;
        SIG_VALID  = 1'b0;
        BUSY       = state != IDLE;
        case (state)
            IDLE: state_next = START ? RUN : IDLE;
            RUN: begin
                DIN_READY  = 1'b1;
                state_next = last ? DONE : RUN;
            end
            DONE: begin
                SIG_VALID  = 1'b1;
                state_next = SIG_ACK ? IDLE : DONE;
            end
            default: state_next = IDLE;
        endcase
        if (CLEAR) state_next = IDLE;
    end

    // Signature, word counter and latched length
    always_ff @(posedge CK or negedge RESET_N) begin
        if (!RESET_N) begin
            SIG   <= SEED;
            count <= '0;
            len_q <= LW'(1);
        end else if (CLEAR) begin
            SIG   <= SEED;
            count <= '0;
        end else if (state == IDLE && START) begin
            SIG   <= SEED;
            count <= '0;
            len_q <= LW'(clamp_len(int'(LEN), MAXLEN));
        end else if (accept) begin
            SIG   <= sig_next;
            count <= count + LW'(1);
        end
    end

endmodule

// File: tb/tb_s35932_misr_compactor.sv
// tb_s35932_misr_compactor: directed checks of the MISR compactor (WIDTH=8, POLY=1D, MAXLEN=16)
module tb_s35932_misr_compactor;

    localparam int LW = 5;

    logic          CK = 1'b0;
    logic          RESET_N, START, DIN_VALID, TM0, TM1, CLEAR, SIG_ACK;
    logic [LW-1:0] LEN;
    logic [7:0]    DIN, SIG;
    logic          DIN_READY, SIG_VALID, BUSY;
    int            checks = 0;
    int            errors = 0;

    s35932_misr_compactor #(
        .WIDTH(8), .POLY(32'h1D), .SEED(8'h00), .MAXLEN(16)
    ) dut (
        .CK(CK), .RESET_N(RESET_N), .START(START), .LEN(LEN),
        .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
        .TM0(TM0), .TM1(TM1), .CLEAR(CLEAR),
        .SIG(SIG), .SIG_VALID(SIG_VALID), .SIG_ACK(SIG_ACK), .BUSY(BUSY)
    );

    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CK);
        #1;
    endtask

    task automatic start(input logic [LW-1:0] len);
        START = 1'b1;
        LEN   = len;
        tick();
        START = 1'b0;
    endtask

    task automatic word(input logic [7:0] d);
        DIN       = d;
        DIN_VALID = 1'b1;
        tick();
        DIN_VALID = 1'b0;
    endtask

    task automatic ack;
        SIG_ACK = 1'b1;
        tick();
        SIG_ACK = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; START = 1'b0; LEN = '0; DIN = '0; DIN_VALID = 1'b0;
        TM0 = 1'b0; TM1 = 1'b0; CLEAR = 1'b0; SIG_ACK = 1'b0;
        #12;
        check("reset_sig", SIG, 8'h00);
        check("reset_valid", SIG_VALID, 1'b0);
        check("reset_busy", BUSY, 1'b0);
        check("reset_ready", DIN_READY, 1'b0);
        RESET_N = 1'b1;
        tick();

        // basic compression 01,80,00 -> 01,82,19
        start(5'd3);
        check("basic_busy", BUSY, 1'b1);
        check("basic_ready", DIN_READY, 1'b1);
        word(8'h01); check("basic_w1", SIG, 8'h01);
        check("basic_novalid_early", SIG_VALID, 1'b0);
        word(8'h80); check("basic_w2", SIG, 8'h82);
        word(8'h00); check("basic_w3", SIG, 8'h19);
        check("basic_valid", SIG_VALID, 1'b1);
        check("basic_done_ready", DIN_READY, 1'b0);
        START = 1'b1;
        tick();
        check("done_start_ignored_valid", SIG_VALID, 1'b1);
        check("done_start_ignored_sig", SIG, 8'h19);
        START = 1'b0;
        ack();
        check("ack_valid", SIG_VALID, 1'b0);
        check("ack_busy", BUSY, 1'b0);
        check("ack_sig_held", SIG, 8'h19);

        // valid gaps with START held high in RUN
        START = 1'b1; LEN = 5'd3;
        tick();
        word(8'h01); check("gap_w1", SIG, 8'h01);
        DIN = 8'hFF;
        tick(); tick(); check("gap_hold1", SIG, 8'h01);
        word(8'h80); check("gap_w2", SIG, 8'h82);
        DIN = 8'hFF;
        tick(); tick(); check("gap_hold2", SIG, 8'h82);
        START = 1'b0;
        word(8'h00); check("gap_w3", SIG, 8'h19);
        check("gap_valid", SIG_VALID, 1'b1);
        ack();

        // scan bypass
        TM0 = 1'b1;
        start(5'd2);
        word(8'hA5); check("tm0_w1", SIG, 8'hA5);
        word(8'h3C); check("tm0_w2", SIG, 8'h3C);
        check("tm0_valid", SIG_VALID, 1'b1);
        ack();

        // test inject
        TM0 = 1'b0; TM1 = 1'b1;
        start(5'd1);
        word(8'h00); check("tm1_sig", SIG, 8'h01);
        check("tm1_valid", SIG_VALID, 1'b1);
        ack();
        TM1 = 1'b0;

        // LEN=0 behaves as one word
        start(5'd0);
        word(8'h5A); check("len0_sig", SIG, 8'h5A);
        check("len0_valid", SIG_VALID, 1'b1);
        ack();

        // LEN=31 clamps to 16 words; bypass mode makes SIG the last word
        TM0 = 1'b1;
        start(5'd31);
        for (int i = 1; i <= 15; i++) word(8'(i));
        check("clamp_15_valid", SIG_VALID, 1'b0);
        check("clamp_15_ready", DIN_READY, 1'b1);
        word(8'h10);
        check("clamp_16_valid", SIG_VALID, 1'b1);
        check("clamp_16_sig", SIG, 8'h10);
        ack();
        TM0 = 1'b0;

        // CLEAR during RUN
        start(5'd3);
        word(8'h01); check("clr_w1", SIG, 8'h01);
        CLEAR = 1'b1; DIN = 8'h80; DIN_VALID = 1'b1;
        tick();
        CLEAR = 1'b0; DIN_VALID = 1'b0;
        check("clr_busy", BUSY, 1'b0);
        check("clr_sig", SIG, 8'h00);
        check("clr_valid", SIG_VALID, 1'b0);
        tick(); tick();
        check("clr_valid_later", SIG_VALID, 1'b0);

        // asynchronous reset in DONE
        start(5'd1);
        word(8'h77); check("rst_pre_sig", SIG, 8'h77);
        check("rst_pre_valid", SIG_VALID, 1'b1);
        #2 RESET_N = 1'b0;
        #1;
        check("rst_async_valid", SIG_VALID, 1'b0);
        check("rst_async_busy", BUSY, 1'b0);
        check("rst_async_sig", SIG, 8'h00);
        #10 RESET_N = 1'b1;
        tick();

        // CLEAR together with SIG_ACK in DONE
        start(5'd1);
        word(8'h33); check("clrack_pre_sig", SIG, 8'h33);
        CLEAR = 1'b1; SIG_ACK = 1'b1;
        tick();
        CLEAR = 1'b0; SIG_ACK = 1'b0;
        check("clrack_busy", BUSY, 1'b0);
        check("clrack_sig", SIG, 8'h00);
        check("clrack_valid", SIG_VALID, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
